// File: rtl/tridiag_pkg.sv
// Shared definitions for the tridiagonal determinant driver: FSM state
// encoding, load-stream word count and the load-order segment bases.
package tridiag_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_ACK,
    ST_DRAIN,
    ST_OUT
  } drv_state_t;

  // Words in one matrix load: b[0..N-1], a[0..N-2], c[0..N-2].
  function automatic int nwords(input int n);
    return 3 * n - 2;
  endfunction

  // Word index of the first element of each segment in the load stream.
  localparam int B_BASE = 0;

  function automatic int a_base(input int n);
    return n;
  endfunction

  function automatic int c_base(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/tridiag_coef_regs.sv
// Coefficient register banks. One word per write, steered by the load-stream
// index into the b, a or c bank; the banks drive the flat buses directly.
// rst clears every element synchronously.
module tridiag_coef_regs
  import tridiag_pkg::*;
#(
  parameter int N     = 16,
  parameter int WIDTH = 16,
  parameter int IDXW  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IDXW-1:0]        idx,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH*(N-1)-1:0] a_flat,
  output logic [WIDTH*N-1:0]     b_flat,
  output logic [WIDTH*(N-1)-1:0] c_flat
);

  localparam int A_BASE = a_base(N);
  localparam int C_BASE = c_base(N);

  // Packed banks: element k sits at bits [WIDTH*(k+1)-1 : WIDTH*k].
  logic [N-1:0][WIDTH-1:0] b_q;
  logic [N-2:0][WIDTH-1:0] a_q;
  logic [N-2:0][WIDTH-1:0] c_q;

  assign b_flat = b_q;
  assign a_flat = a_q;
  assign c_flat = c_q;

  for (genvar k = 0; k < N; k++) begin : g_b
    // b[k] captures the word whose stream index is B_BASE+k.
    always_ff @(posedge clk) begin
      if (rst)
        b_q[k] <= '0;
      else if (we && idx == IDXW'(B_BASE + k))
        b_q[k] <= wdata;
    end
  end

  for (genvar k = 0; k < N - 1; k++) begin : g_ac
    // a[k] captures the word whose stream index is A_BASE+k.
    always_ff @(posedge clk) begin
      if (rst)
        a_q[k] <= '0;
      else if (we && idx == IDXW'(A_BASE + k))
        a_q[k] <= wdata;
    end

    // c[k] captures the word whose stream index is C_BASE+k.
    always_ff @(posedge clk) begin
      if (rst)
        c_q[k] <= '0;
      else if (we && idx == IDXW'(C_BASE + k))
        c_q[k] <= wdata;
    end
  end

endmodule

// File: rtl/tridiag_det_driver.sv
// Initiator-side controller for the tridiagonal determinant engine.
// Collects 3N-2 coefficient words, pulses start, waits for done, captures
// det, pulses ack, waits for done to fall, then offers the result on a
// valid/ready port. Optional watchdog: define TRIDIAG_DRV_TIMEOUT_EN to abort
// a WAIT that lasts TIMEOUT cycles with res_err=1 and res_data=0.
module tridiag_det_driver
  import tridiag_pkg::*;
#(
  parameter int N       = 16,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic [WIDTH*(N-1)-1:0] a_flat,
  output logic [WIDTH*N-1:0]     b_flat,
  output logic [WIDTH*(N-1)-1:0] c_flat,
  output logic                   start,
  input  logic                   done,
  input  logic [2*WIDTH-1:0]     det,
  output logic                   ack,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*WIDTH-1:0]     res_data,
  output logic                   res_err,
  output logic                   busy
);

  localparam int NW   = nwords(N);
  localparam int IDXW = $clog2(NW);

  if (N < 3 || N > 16 || WIDTH < 1 || WIDTH > 16 || TIMEOUT < 1) begin : g_bad_param
    $error("tridiag_det_driver: illegal parameter set");
  end

  drv_state_t      state;
  logic [IDXW-1:0] idx;
  logic            we;

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_LOAD);
  assign we       = in_valid & in_ready;

  tridiag_coef_regs #(
    .N     (N),
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_coef (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .idx    (idx),
    .wdata  (in_data),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .c_flat (c_flat)
  );

`ifdef TRIDIAG_DRV_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] wait_cnt;
  logic           err_q;
  assign res_err = err_q;
`else
  assign res_err = 1'b0;
`endif

  // Handshake FSM; start/ack are one-cycle pulses raised on entry to their state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      start     <= 1'b0;
      ack       <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef TRIDIAG_DRV_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      ack   <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (we) begin
            if (idx == IDXW'(NW - 1)) begin
              idx   <= '0;
              start <= 1'b1;
              state <= ST_START;
            end else begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        ST_START: begin
`ifdef TRIDIAG_DRV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done already high here is fresh: DRAIN saw it low before START.
          if (done) begin
            res_data <= det;
`ifdef TRIDIAG_DRV_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            ack      <= 1'b1;
            state    <= ST_ACK;
          end
`ifdef TRIDIAG_DRV_TIMEOUT_EN
          else if (wait_cnt == TOW'(TIMEOUT - 1)) begin
            res_data  <= '0;
            err_q     <= 1'b1;
            res_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            wait_cnt <= wait_cnt + TOW'(1);
          end
`endif
        end
        ST_ACK: begin
          state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Engine drops done a cycle after leaving its result state.
          if (!done) begin
            res_valid <= 1'b1;
            state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: doc/tridiag_det_driver.md
# tridiag_det_driver

Initiator-side controller for the tridiagonal determinant engine. Accepts matrix coefficients as a serial word stream, assembles the flattened a/b/c buses, and issues `start`. It then waits for `done`, captures `det`, acknowledges with `ack`, and presents the result on a valid/ready output port. It sits between the host-facing MMIO/stream logic and the determinant engine, sharing the engine's clock and reset.

## Interface
- `N`, 16: matrix order, 3..16; must match the engine.
- `WIDTH`, 16: coefficient width, ≤16; result is `2*WIDTH`.
- `TIMEOUT`, 64: watchdog limit in cycles; used only with `TRIDIAG_DRV_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  coefficient word valid.
- `in_ready`  out  1  driver can accept a word.
- `in_data`  in  WIDTH  coefficient word, raw two's-complement bits.
- `a_flat`  out  WIDTH*(N-1)  a[k] at bits [WIDTH*(k+1)-1 : WIDTH*k].
- `b_flat`  out  WIDTH*N  b[k], same packing.
- `c_flat`  out  WIDTH*(N-1)  c[k], same packing.
- `start`  out  1  one-cycle request to the engine.
- `done`  in  1  engine result valid, held until acked.
- `det`  in  2*WIDTH  engine result.
- `ack`  out  1  one-cycle result acknowledge.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_data`  out  2*WIDTH  captured determinant.
- `res_err`  out  1  result is a timeout abort; tied 0 without the macro.
- `busy`  out  1  high in every state except LOAD.

## Operation
- Load order is fixed: b[0..N-1], then a[0..N-2], then c[0..N-2]. That is `NWORDS = 3N-2` words.
- A word index counter runs 0..NWORDS-1. A word is written when `in_valid & in_ready`.
- The coefficient registers drive the flat buses directly. They are written only in LOAD, so they stay stable from START until DRAIN completes.
- FSM states and transitions:
  - LOAD: `in_ready=1`. On acceptance of word NWORDS-1, go to START and clear the index.
  - START: `start=1` for exactly this cycle, then go to WAIT.
  - WAIT: if `done=1`, capture `det` into `res_data`, clear `res_err`, and go to ACK.
  - ACK: `ack=1` for exactly this cycle, then go to DRAIN.
  - DRAIN: wait for `done=0`. This is at least one cycle, because the engine clears `done` one cycle after returning to idle. Then go to OUT.
  - OUT: `res_valid=1`. On `res_valid & res_ready`, go to LOAD.
- Arithmetic: none in the datapath. Bits pass through unchanged, and sign interpretation belongs to the engine.
- `in_valid` is ignored outside LOAD.
- `res_ready` is ignored outside OUT.
- A `done` that is already high on entry to WAIT is treated as a fresh result. It cannot be stale, because DRAIN guarantees `done=0` before the next START.
- Reset at any point has the same effect:
  - State returns to LOAD with index 0.
  - Partial coefficients are discarded and the registers are cleared to 0.
  - No `start` or `ack` is emitted in the reset cycle.

## Timing
- Reset values: `in_ready=1` (state is LOAD), `start=0`, `ack=0`, `res_valid=0`, `res_data=0`, `res_err=0`, `busy=0`, all flat buses 0.
- `start` is registered and is high in the cycle after the last word handshake.
- `ack` is registered and is high in the cycle after `done` is sampled high in WAIT.
- Earliest `res_valid` is 3 cycles after `done` is first sampled high: the ACK cycle, at least one DRAIN cycle, then OUT.
- Throughput: one matrix in flight. The next load begins the cycle after the result handshake.
- `res_data` and `res_err` are stable for the whole OUT interval.

## Configuration
- `TRIDIAG_DRV_TIMEOUT_EN` defined: a cycle counter runs in WAIT.
  - If it reaches `TIMEOUT` without `done`, go directly to OUT with `res_err=1` and `res_data=0`.
  - No `ack` is issued in that case.
- `TRIDIAG_DRV_TIMEOUT_EN` undefined: WAIT waits indefinitely, and `res_err` is constant 0.

## Structure
- Shared package `tridiag_pkg` holds:
  - the state enum (LOAD, START, WAIT, ACK, DRAIN, OUT);
  - the `NWORDS` helper;
  - the load-order segment base constants B_BASE=0, A_BASE=N, C_BASE=2N-1.
- One sub-module, `tridiag_coef_regs`: indexed word write into the packed a/b/c register banks, with a synchronous clear.

## Test plan
- N=4, WIDTH=16, b=[2,2,2,2], a=c=[1,1,1], engine attached:
  - one `start` pulse after the 10th word;
  - `res_data=0x00000005`, `res_err=0`.
- N=4, b=[0,0,0,0], a=c=[1,1,1] -> `res_data=0x00000001`.
- N=3, b=[0xFFFF,2,3], a=c=[0,0] -> `res_data=0xFFFFFFFA` (−6).
- `res_ready` held low 10 cycles in OUT:
  - `res_valid` and `res_data` stay stable, `in_ready=0`;
  - the next load is accepted only after the handshake.
- `rst` pulsed after 5 words, then a full 10-word load -> correct det, and no `start` before word 10.
- Macro defined, `TIMEOUT=64`, engine stubbed with `done=0` -> `res_valid` 64 cycles after entering WAIT, `res_err=1`, `res_data=0`, `ack` never asserted.
